// File: rtl/mcadd_module_pkg.sv
// Shared types and defaults for the multi-cycle adder.
// State encodings and default operand/slice widths.
package mcadd_module_pkg;

  localparam int MCADD_WIDTH = 64;
  localparam int MCADD_CHUNK = 16;

  typedef enum logic [1:0] {
    MCADD_IDLE = 2'd0,
    MCADD_RUN  = 2'd1,
    MCADD_DONE = 2'd2
  } mcadd_state_e;

endpackage

// File: rtl/mcadd_module_addcin.sv
// Narrow adder primitive with carry-in.
// The caller widens operands by one bit to recover carry-out.
module addcin_module #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s
);

  assign s = a + b + WIDTH'(cin);

endmodule

// File: rtl/mcadd_module.sv
// Multi-cycle wide add/sub: one CHUNK-bit slice per cycle.
// Optional operand isolation of the slice adder: MCADD_OPIS_EN.
module mcadd_module
  import mcadd_module_pkg::*;
#(
  parameter int WIDTH = MCADD_WIDTH,
  parameter int CHUNK = MCADD_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad
    $error("mcadd_module: WIDTH must be a multiple of CHUNK");
  end

  mcadd_state_e state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r, q_r, q_nxt;
  logic             c_r;
  logic [CW-1:0]    cnt;
  logic             last;

  logic [CHUNK:0]   add_a, add_b, sum;
  logic             add_c;

  assign last = (cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= MCADD_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      MCADD_IDLE: if (in_valid)  state_nxt = MCADD_RUN;
      MCADD_RUN:  if (last)      state_nxt = MCADD_DONE;
      MCADD_DONE: if (out_ready) state_nxt = MCADD_IDLE;
      default:                   state_nxt = MCADD_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    in_ready  = (state == MCADD_IDLE);
    busy      = (state == MCADD_RUN);
    out_valid = (state == MCADD_DONE);
  end

`ifdef MCADD_OPIS_EN
  assign add_a = {1'b0, a_r[CHUNK-1:0]} & {(CHUNK+1){busy}};
  assign add_b = {1'b0, b_r[CHUNK-1:0]} & {(CHUNK+1){busy}};
  assign add_c = c_r & busy;
`else
  assign add_a = {1'b0, a_r[CHUNK-1:0]};
  assign add_b = {1'b0, b_r[CHUNK-1:0]};
  assign add_c = c_r;
`endif

  addcin_module #(
    .WIDTH(CHUNK + 1)
  ) u_slice (
    .a  (add_a),
    .b  (add_b),
    .cin(add_c),
    .s  (sum)
  );

  // New slice enters at the MSBs; oldest slice ends up at the LSBs
  assign q_nxt = (q_r >> CHUNK)
               | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  // Operand capture, slice shifting, carry ripple and result latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      q_r  <= '0;
      c_r  <= 1'b0;
      cnt  <= '0;
      q    <= '0;
      cout <= 1'b0;
    end else begin
      unique case (state)
        MCADD_IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= sub ? ~b : b;
            c_r <= cin ^ sub;
            cnt <= '0;
          end
        end
        MCADD_RUN: begin
          a_r <= a_r >> CHUNK;
          b_r <= b_r >> CHUNK;
          q_r <= q_nxt;
          c_r <= sum[CHUNK];
          cnt <= cnt + 1'b1;
          if (last) begin
            q    <= q_nxt;
            cout <= sum[CHUNK];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcadd_module.sv
// Directed and light random checks for mcadd_module.
// Expected results come from a 65-bit arithmetic model.
module tb_mcadd_module;

  localparam int WIDTH  = 64;
  localparam int CHUNK  = 16;
  localparam int NSLICE = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, q;
  logic             cin, sub;
  logic             out_valid, out_ready;
  logic             cout, busy;

  int total = 0;
  int bad   = 0;

  mcadd_module #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .cout     (cout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [63:0] x, y,
                                        input logic c, s);
    logic [64:0] r;
    if (!s) begin
      r = {1'b0, x} + {1'b0, y} + 65'(c);
    end else begin
      r = {1'b0, x} - {1'b0, y} - 65'(c);
      r[64] = ~r[64];
    end
    return r;
  endfunction

  // Accept one op, scramble the inputs, check exact latency and result
  task automatic do_op(input string tag, input logic [63:0] ta, tb_,
                       input logic tc, ts, input logic [64:0] exp);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cin = ~tc; sub = ~ts;
    chk({tag, "_busy"}, busy, 1'b1);
    for (int k = 1; k <= NSLICE; k++) begin
      @(negedge clk);
      if (k < NSLICE) chk({tag, "_early"}, out_valid, 1'b0);
      else            chk({tag, "_valid"}, out_valid, 1'b1);
    end
    chk({tag, "_q"}, q, exp[63:0]);
    chk({tag, "_cout"}, cout, exp[64]);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel_ov"}, out_valid, 1'b0);
    chk({tag, "_rel_ir"}, in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] ra, rb;
    logic        rc, rs;
    logic [64:0] e;
    int          wait_n;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_q", q, 64'h0);
    chk("rst_cout", cout, 1'b0);
    rst_n = 1'b1;

    do_op("add_small", 64'h1, 64'h2, 1'b0, 1'b0, {1'b0, 64'h3});
    release_out("add_small");

    do_op("add_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          {1'b1, 64'h0});
    release_out("add_ripple");

    do_op("sub_borrow", 64'h0, 64'h1, 1'b0, 1'b1,
          {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    release_out("sub_borrow");

    do_op("sub_cin", 64'h10, 64'h3, 1'b1, 1'b1, {1'b1, 64'hC});
    release_out("sub_cin");

    do_op("add_cin", 64'h0000_FFFF_0000_FFFF, 64'h0, 1'b1, 1'b0,
          {1'b0, 64'h0000_FFFF_0001_0000});

    // Backpressure: result held, new requests ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 64'h1234; b = 64'h5678;
      cin = 1'b0; sub = 1'b0;
      chk("bp_q", q, 64'h0000_FFFF_0001_0000);
      chk("bp_cout", cout, 1'b0);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    release_out("bp");
    chk("bp_q_hold", q, 64'h0000_FFFF_0001_0000);

`ifdef MCADD_OPIS_EN
    chk("opis_idle", {dut.add_a, dut.add_b, dut.add_c}, 64'h0);
`endif

    // Reset during the second RUN cycle drops the operation
    @(negedge clk);
    a = 64'h5; b = 64'h6; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_q", q, 64'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_result", out_valid, 1'b0);
    end

    // Random ops with random gaps on both handshakes
    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 8 == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
      rc = 1'($urandom);
      rs = 1'($urandom);
      e  = model(ra, rb, rc, rs);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      a = ra; b = rb; cin = rc; sub = rs; in_valid = 1'b1;
      wait_n = 0;
      while (!in_ready && wait_n < 20) begin
        @(negedge clk);
        wait_n++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      a = '0; b = '0;
      wait_n = 0;
      while (!out_valid && wait_n < 20) begin
        @(negedge clk);
        wait_n++;
      end
      chk("rnd_valid", out_valid, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rnd_hold", q, e[63:0]);
      end
      chk("rnd_q", q, e[63:0]);
      chk("rnd_cout", cout, e[64]);
      release_out("rnd");
`ifdef MCADD_OPIS_EN
      chk("opis_rnd", {dut.add_a, dut.add_b, dut.add_c}, 64'h0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
